fp_sqrt_seq: RTL
================

FP_SQRT_SEQ -- requirements
Module: fp_sqrt_seq

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request; accepted only when the FSM is in IDLE.
REQ-005 data_i  input  32  IEEE-754 single-precision operand, captured on an accepted start.
REQ-006 data_o  output  32  IEEE-754 single-precision square root of the captured operand.
REQ-007 busy  output  1  high in CALC and DONE; low in IDLE.
REQ-008 done  output  1  one-cycle pulse, high while in DONE; data_o and invalid are valid from this cycle.
REQ-009 invalid  output  1  high with the result when the operand is negative nonzero or NaN.

Function
REQ-010 The FSM SHALL have the states IDLE, CALC and DONE; IDLE is entered on reset.
REQ-011 IDLE to CALC: on an edge with start=1 and a normal positive operand; data_i SHALL be captured on that edge.
REQ-012 IDLE to DONE: on an edge with start=1 and a special-case operand (REQ-016..REQ-019); the result SHALL be loaded on that same edge.
REQ-013 CALC SHALL last exactly 24 cycles, one root bit per cycle, MSB first, using a 5-bit iteration counter; it then moves to DONE.
REQ-014 DONE SHALL last exactly one cycle and then return to IDLE; a start seen during that DONE cycle SHALL be ignored.
REQ-015 start while busy=1 SHALL be ignored; data_i changes while busy SHALL NOT affect the result.
REQ-016 Zero operand (exp=0, mantissa=0, either sign) SHALL produce data_o equal to the operand and invalid=0.
REQ-017 Denormal operand (exp=0, mantissa!=0, either sign) SHALL be flushed, producing data_o=0x00000000 and invalid=0.
REQ-018 +Inf SHALL produce 0x7F800000 with invalid=0.
REQ-019 NaN, and any negative nonzero non-denormal operand (including -Inf), SHALL produce 0x7FC00000 with invalid=1.
REQ-020 Normal operand, exponent and radicand: let E=exp-127.
- E even: rad = {2'b01, m[22:0], 23'b0}.
- E odd: rad = {1'b1, m[22:0], 24'b0} and E becomes E-1.
REQ-021 Normal operand, root: rad SHALL be 48 bits; a restoring integer square root SHALL yield a 24-bit root Q with Q[23]=1 and a remainder of at least 26 bits.
REQ-022 Normal operand, packing: data_o = {1'b0, (E/2)+127, Q[22:0]}; the result is truncated with no rounding, and the exponent SHALL always be 1..254.
REQ-023 Latency, normal operand: start accepted on edge k gives done=1 in the cycle after edge k+24 (25 cycles from accept).
REQ-024 Latency, special-case operand: start accepted on edge k gives done=1 in the cycle after edge k.
REQ-025 data_o and invalid SHALL hold their values from DONE until the next result load.
- Special case: they are replaced on the accepting edge.
- Normal operand: they are replaced on the CALC-to-DONE edge.

Reset
REQ-026 With rst_n=0 at a rising edge, the state SHALL become IDLE and busy, done, invalid, data_o, the counter and the datapath registers SHALL all become 0, regardless of current state.
REQ-027 A reset asserted mid-CALC SHALL abort the operation with no done pulse; a start on the first edge after release SHALL be accepted normally.

Verification
REQ-028 data_i=0x40800000 (4.0), start pulse -> done after 25 cycles, data_o=0x40000000, invalid=0.
REQ-029 data_i=0x40000000 (2.0) -> data_o=0x3FB504F3; data_i=0x3F800000 (1.0) -> 0x3F800000; data_i=0x41100000 (9.0) -> 0x40400000.
REQ-030 data_i=0xBF800000 -> done after 1 cycle, data_o=0x7FC00000, invalid=1; data_i=0x80000000 -> 0x80000000, invalid=0; data_i=0x7F800000 -> 0x7F800000.
REQ-031 Start 0x40800000, then start=1 with data_i=0x41100000 held through CALC and DONE -> single done, data_o=0x40000000; 9.0 accepted only once back in IDLE.
REQ-032 rst_n=0 for one cycle at CALC iteration 10 -> no done pulse, all outputs 0; a following start with 0x41800000 -> 0x40800000.

Source files
------------

// File: rtl/fp_sqrt_seq.sv
// ============================================================================
// Module      : fp_sqrt_seq
// Description : Sequential IEEE-754 single-precision square root, one root
//               bit per cycle (restoring algorithm), truncated result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_sqrt_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy,
    output logic        done,
    output logic        invalid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0]  C_LAST_ITER = 5'd23;
    localparam logic [31:0] C_QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] C_POS_INF   = 32'h7F80_0000;

    state_t      state_q;
    logic [47:0] rad_q;
    logic [25:0] rem_q;
    logic [23:0] root_q;
    logic [7:0]  exp_q;
    logic [4:0]  cnt_q;
    logic [31:0] data_o_q;
    logic        busy_q;
    logic        done_q;
    logic        invalid_q;

    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_man;
    logic        is_special;
    logic [31:0] spec_data;
    logic        spec_inv;
    logic [47:0] rad_init;
    logic [7:0]  res_exp;

    logic [27:0] rem_shift;
    logic [27:0] trial;
    logic        trial_ge;
    logic [25:0] rem_d;
    logic [23:0] root_d;

    assign op_sign = data_i[31];
    assign op_exp  = data_i[30:23];
    assign op_man  = data_i[22:0];

    // Odd biased exponent means an even unbiased exponent, so the mantissa
    // sits one bit lower in the radicand; (exp+127)>>1 covers both parities.
    assign rad_init = op_exp[0] ? {2'b01, op_man, 23'b0} : {1'b1, op_man, 24'b0};
    assign res_exp  = 8'(({1'b0, op_exp} + 9'd127) >> 1);

    always_comb begin
        is_special = 1'b1;
        spec_data  = 32'h0000_0000;
        spec_inv   = 1'b0;
        if (op_exp == 8'h00) begin
            spec_data = (op_man == 23'd0) ? data_i : 32'h0000_0000;
        end else if (op_exp == 8'hFF) begin
            if ((op_man == 23'd0) && !op_sign) begin
                spec_data = C_POS_INF;
            end else begin
                spec_data = C_QNAN;
                spec_inv  = 1'b1;
            end
        end else if (op_sign) begin
            spec_data = C_QNAN;
            spec_inv  = 1'b1;
        end else begin
            is_special = 1'b0;
        end
    end

    assign rem_shift = {rem_q, rad_q[47:46]};
    assign trial     = {2'b00, root_q, 2'b01};
    assign trial_ge  = (rem_shift >= trial);
    assign rem_d     = trial_ge ? 26'(rem_shift - trial) : rem_shift[25:0];
    assign root_d    = {root_q[22:0], trial_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            data_o_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (is_special) begin
                            data_o_q  <= spec_data;
                            invalid_q <= spec_inv;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            rad_q   <= rad_init;
                            rem_q   <= '0;
                            root_q  <= '0;
                            exp_q   <= res_exp;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rad_q  <= {rad_q[45:0], 2'b00};
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == C_LAST_ITER) begin
                        data_o_q  <= {1'b0, exp_q, root_d[22:0]};
                        invalid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o  = data_o_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign invalid = invalid_q;

endmodule

`default_nettype wire
